// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the painter stage and video DAC.
interface vga_timing_gen_if;
  logic [9:0] horzCoord;
  logic [9:0] vertCoord;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic       sync_n;
  logic       vga_clk;
  logic       line_start;
  logic       frame_start;

  modport master (
    output horzCoord, vertCoord, hsync, vsync, blank_n, sync_n, vga_clk,
           line_start, frame_start
  );

  modport slave (
    input horzCoord, vertCoord, hsync, vsync, blank_n, sync_n, vga_clk,
          line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides clk into a pixel tick, runs the horizontal and
// vertical counters over the full raster and registers every qualifier from the next
// counter values so coordinates, syncs, blanking and pulses stay aligned on one edge.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // Region bounds kept 11 bits wide so an end bound of 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG    = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG    = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  if (CLK_DIV < 1 || H_TOTAL < 1 || V_TOTAL < 1 || H_TOTAL > 1024 || V_TOTAL > 1024)
  begin : g_bad_params
    $error("vga_timing_gen: CLK_DIV must be >= 1 and raster totals must fit 10 bits");
  end

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       h;
  logic [9:0]       h_next;
  logic [9:0]       v;
  logic [9:0]       v_next;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             hsync_q;
  logic             hsync_next;
  logic             vsync_q;
  logic             vsync_next;
  logic             blank_q;
  logic             blank_next;
  logic             vga_clk_q;
  logic             vga_clk_next;
  logic             line_q;
  logic             frame_q;

  // Next divider/counter values and the qualifiers derived from those next values.
  always_comb begin
    tick       = (div == DIV_LAST);
    div_next   = tick ? '0 : div + 1'b1;
    h_wrap     = tick && (h == H_LAST);
    v_wrap     = h_wrap && (v == V_LAST);
    h_next     = h;
    v_next     = v;
    if (tick) begin
      h_next = h_wrap ? '0 : h + 10'd1;
    end
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v + 10'd1;
    end
    hsync_next   = (({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_next   = (({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END)) ? SYNC_POL : ~SYNC_POL;
    blank_next   = ({1'b0, h_next} < H_VIS_END) && ({1'b0, v_next} < V_VIS_END);
    vga_clk_next = (div_next >= DIV_HALF);
  end

  // Raster state and registered outputs; async reset aborts the raster immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div       <= '0;
      h         <= '0;
      v         <= '0;
      hsync_q   <= ~SYNC_POL;
      vsync_q   <= ~SYNC_POL;
      blank_q   <= 1'b1;
      vga_clk_q <= 1'b0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      div       <= div_next;
      h         <= h_next;
      v         <= v_next;
      hsync_q   <= hsync_next;
      vsync_q   <= vsync_next;
      blank_q   <= blank_next;
      vga_clk_q <= vga_clk_next;
      line_q    <= h_wrap;
      frame_q   <= v_wrap;
    end
  end

  assign vga.horzCoord   = h;
  assign vga.vertCoord   = v;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.blank_n     = blank_q;
  assign vga.sync_n      = 1'b0;
  assign vga.vga_clk     = vga_clk_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (small raster CLK_DIV=3 active-high sync,
// small raster CLK_DIV=1, default 640x480) checked every clk against an arithmetic
// raster model, plus a checkpoint table, async-reset and whole-frame sequences.
module tb_vga_timing_gen;

  localparam int unsigned A_D = 3, A_HV = 8, A_HF = 2, A_HS = 3, A_HB = 2;
  localparam int unsigned A_VV = 4, A_VF = 1, A_VS = 2, A_VB = 1;
  localparam logic        A_POL = 1'b1;
  localparam int unsigned A_HT = A_HV + A_HF + A_HS + A_HB;
  localparam int unsigned A_VT = A_VV + A_VF + A_VS + A_VB;
  localparam int unsigned A_FR = A_HT * A_VT * A_D;

  localparam int unsigned B_D = 1, B_HV = 6, B_HF = 1, B_HS = 2, B_HB = 1;
  localparam int unsigned B_VV = 3, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam logic        B_POL = 1'b0;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic hs, vs, bl, sn, vc, ls, fs;
  } outs_t;

  typedef struct {
    int unsigned k;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs, bl, vc, ls;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen #(
    .CLK_DIV(A_D), .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB), .SYNC_POL(A_POL)
  ) dut_a (.clk(clk), .rst(rst_a), .vga(if_a));

  vga_timing_gen #(
    .CLK_DIV(B_D), .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .SYNC_POL(B_POL)
  ) dut_b (.clk(clk), .rst(rst_b), .vga(if_b));

  vga_timing_gen dut_c (.clk(clk), .rst(rst_c), .vga(if_c));

  outs_t got_a, got_b, got_c;
  assign got_a = {if_a.horzCoord, if_a.vertCoord, if_a.hsync, if_a.vsync, if_a.blank_n,
                  if_a.sync_n, if_a.vga_clk, if_a.line_start, if_a.frame_start};
  assign got_b = {if_b.horzCoord, if_b.vertCoord, if_b.hsync, if_b.vsync, if_b.blank_n,
                  if_b.sync_n, if_b.vga_clk, if_b.line_start, if_b.frame_start};
  assign got_c = {if_c.horzCoord, if_c.vertCoord, if_c.hsync, if_c.vsync, if_c.blank_n,
                  if_c.sync_n, if_c.vga_clk, if_c.line_start, if_c.frame_start};

  // clk edges seen since each reset was released
  int unsigned ka, kb, kc;
  always @(posedge clk or posedge rst_a) if (rst_a) ka <= 0; else ka <= ka + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) kb <= 0; else kb <= kb + 1;
  always @(posedge clk or posedge rst_c) if (rst_c) kc <= 0; else kc <= kc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Raster position from elapsed clk edges: pixel index = edges / divisor.
  function automatic outs_t model(input int unsigned k, input int unsigned d,
                                  input int unsigned hv, input int unsigned hf,
                                  input int unsigned hs, input int unsigned hb,
                                  input int unsigned vv, input int unsigned vf,
                                  input int unsigned vs, input int unsigned vb,
                                  input logic pol);
    int unsigned ht = hv + hf + hs + hb;
    int unsigned vt = vv + vf + vs + vb;
    int unsigned p  = k / d;
    int unsigned h  = p % ht;
    int unsigned v  = (p / ht) % vt;
    logic on_tick   = (k > 0) && (k % d == 0);
    outs_t o;
    o.h  = 10'(h);
    o.v  = 10'(v);
    o.hs = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
    o.vs = (v >= vv + vf && v < vv + vf + vs) ? pol : ~pol;
    o.bl = (h < hv) && (v < vv);
    o.sn = 1'b0;
    o.vc = (k == 0) ? 1'b0 : ((k % d) >= d / 2);
    o.ls = on_tick && (h == 0);
    o.fs = on_tick && (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic outs_t model_a(input int unsigned k);
    return model(k, A_D, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_POL);
  endfunction

  function automatic outs_t model_b(input int unsigned k);
    return model(k, B_D, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_POL);
  endfunction

  function automatic outs_t model_c(input int unsigned k);
    return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
  endfunction

  int unsigned hs_low_c = 0;

  // Every clk, every build against the model, sampled mid-cycle.
  always @(negedge clk) begin
    check("A raster", 32'(got_a), 32'(model_a(ka)));
    check("B raster", 32'(got_b), 32'(model_b(kb)));
    check("C raster", 32'(got_c), 32'(model_c(kc)));
    if (!rst_c && kc >= 1 && kc <= 1600 && !if_c.hsync) hs_low_c++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  vec_t tbl [12];

  initial begin
    int unsigned guard;
    int unsigned n, vs_cnt, bl_cnt, ls_cnt, bl_late;

    tbl[0]  = '{k: 0,    h: 0,   v: 0, hs: 1, bl: 1, vc: 0, ls: 0};
    tbl[1]  = '{k: 1,    h: 0,   v: 0, hs: 1, bl: 1, vc: 1, ls: 0};
    tbl[2]  = '{k: 2,    h: 1,   v: 0, hs: 1, bl: 1, vc: 0, ls: 0};
    tbl[3]  = '{k: 1279, h: 639, v: 0, hs: 1, bl: 1, vc: 1, ls: 0};
    tbl[4]  = '{k: 1280, h: 640, v: 0, hs: 1, bl: 0, vc: 0, ls: 0};
    tbl[5]  = '{k: 1311, h: 655, v: 0, hs: 1, bl: 0, vc: 1, ls: 0};
    tbl[6]  = '{k: 1312, h: 656, v: 0, hs: 0, bl: 0, vc: 0, ls: 0};
    tbl[7]  = '{k: 1503, h: 751, v: 0, hs: 0, bl: 0, vc: 1, ls: 0};
    tbl[8]  = '{k: 1504, h: 752, v: 0, hs: 1, bl: 0, vc: 0, ls: 0};
    tbl[9]  = '{k: 1599, h: 799, v: 0, hs: 1, bl: 0, vc: 1, ls: 0};
    tbl[10] = '{k: 1600, h: 0,   v: 1, hs: 1, bl: 1, vc: 0, ls: 1};
    tbl[11] = '{k: 1601, h: 0,   v: 1, hs: 1, bl: 1, vc: 1, ls: 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;

    // Default-build checkpoints across the first line.
    for (int i = 0; i < 12; i++) begin
      guard = 0;
      while (kc < tbl[i].k && guard < 4000) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("C table k=%0d reached", tbl[i].k), kc, tbl[i].k);
      check($sformatf("C table k=%0d", tbl[i].k),
            32'({if_c.horzCoord, if_c.vertCoord, if_c.hsync, if_c.blank_n,
                 if_c.vga_clk, if_c.line_start}),
            32'({tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].bl, tbl[i].vc, tbl[i].ls}));
    end
    check("C hsync low clks in line 0", hs_low_c, 192);

    // Async reset while hsync is active in the middle of the frame.
    guard = 0;
    while (!(if_a.horzCoord == 10'd11 && if_a.vertCoord == 10'd2) && guard < 2 * A_FR) begin
      @(negedge clk);
      guard++;
    end
    check("A reached h=11 v=2", 32'(if_a.horzCoord == 10'd11 && if_a.vertCoord == 10'd2), 1);
    check("A hsync active before reset", 32'(if_a.hsync), 32'(A_POL));
    #2;
    rst_a = 1'b1;
    #1;
    check("A async reset values", 32'(got_a), 32'(model_a(0)));
    repeat (2) @(negedge clk);
    #1;
    rst_a = 1'b0;
    repeat (A_D - 1) @(posedge clk);
    #1;
    check("A holds h=0 before first tick", 32'(if_a.horzCoord), 0);
    @(posedge clk);
    #1;
    check("A first tick after release", 32'(if_a.horzCoord), 1);

    // One whole frame between frame_start pulses.
    guard = 0;
    while (!if_a.frame_start && guard < 2 * A_FR) begin
      @(negedge clk);
      guard++;
    end
    check("A frame_start seen", 32'(if_a.frame_start), 1);
    n = 0; vs_cnt = 0; bl_cnt = 0; ls_cnt = 0; bl_late = 0;
    do begin
      @(negedge clk);
      n++;
      if (if_a.vsync == A_POL) vs_cnt++;
      if (if_a.blank_n) bl_cnt++;
      if (if_a.line_start) ls_cnt++;
      if (if_a.blank_n && if_a.vertCoord >= 10'(A_VV)) bl_late++;
    end while (!if_a.frame_start && n < 2 * A_FR);
    check("A frame period clks", n, A_FR);
    check("A vsync active clks", vs_cnt, A_VS * A_HT * A_D);
    check("A blank_n high clks", bl_cnt, A_HV * A_VV * A_D);
    check("A line_start pulses per frame", ls_cnt, A_VT);
    check("A blank_n high below visible", bl_late, 0);

    // Random async resets at random points of the raster.
    repeat (24) begin
      int unsigned which;
      n = $urandom_range(1, 120);
      repeat (n) @(negedge clk);
      which = $urandom_range(0, 1);
      #($urandom_range(1, 3));
      if (which == 0) begin
        rst_a = 1'b1;
        #1;
        check("A random async reset", 32'(got_a), 32'(model_a(0)));
      end else begin
        rst_b = 1'b1;
        #1;
        check("B random async reset", 32'(got_b), 32'(model_b(0)));
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
    end
    repeat (200) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
